// File: rtl/clock_pkg.sv
// Shared widths, limits and the alarm channel state encoding for the multi-alarm clock.
package clock_pkg;
   localparam int HOUR_W   = 5;
   localparam int MIN_W    = 6;
   localparam int SEC_W    = 6;
   localparam int MAX_HOUR = 23;
   localparam int MAX_MIN  = 59;
   localparam int MAX_SEC  = 59;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } alarm_state_t;
endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: ring/snooze sequencing with its ring-length and snooze counters.
//
//   state  | meaning
//   IDLE   | silent, waiting for a time match
//   RING   | buzzer on, ring_cnt counts seconds up to RING_SEC
//   SNOOZE | silent, snz_cnt counts down from SNOOZE_SEC, then rings again
module alarm_channel
   import clock_pkg::*;
#(
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sec_tick,
   input  logic match,
   input  logic en,
   input  logic stop,
   input  logic snooze,
   output logic ringing
);
   localparam int RING_W = $clog2(RING_SEC + 1);
   localparam int SNZ_W  = $clog2(SNOOZE_SEC + 1);

   alarm_state_t      state;
   logic [RING_W-1:0] ring_cnt;
   logic [SNZ_W-1:0]  snz_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         ring_cnt <= '0;
         snz_cnt  <= '0;
         ringing  <= 1'b0;
      end else if (!en || stop) begin
         state    <= IDLE;
         ring_cnt <= '0;
         snz_cnt  <= '0;
         ringing  <= 1'b0;
      end else if (match && state != RING) begin
         // a match while already ringing must not restart the ring period
         state    <= RING;
         ring_cnt <= '0;
         snz_cnt  <= '0;
         ringing  <= 1'b1;
      end else begin
         case (state)
            RING: begin
               if (snooze) begin
                  state    <= SNOOZE;
                  ring_cnt <= '0;
                  snz_cnt  <= SNZ_W'(SNOOZE_SEC);
                  ringing  <= 1'b0;
               end else if (sec_tick) begin
                  if (ring_cnt == RING_W'(RING_SEC - 1)) begin
                     state    <= IDLE;
                     ring_cnt <= '0;
                     ringing  <= 1'b0;
                  end else begin
                     ring_cnt <= ring_cnt + RING_W'(1);
                  end
               end
            end
            SNOOZE: begin
               if (sec_tick) begin
                  if (snz_cnt == SNZ_W'(1)) begin
                     state    <= RING;
                     ring_cnt <= '0;
                     snz_cnt  <= '0;
                     ringing  <= 1'b1;
                  end else begin
                     snz_cnt <= snz_cnt - SNZ_W'(1);
                  end
               end
            end
            default: begin
               state   <= IDLE;
               ringing <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: rtl/multi_alarm_clock.sv
// 24-hour time-of-day counter with load checking, 12/24-hour display and
// NUM_ALARMS independent alarm channels driven from the 1 Hz sec_tick.
module multi_alarm_clock
   import clock_pkg::*;
#(
   parameter int NUM_ALARMS = 4,
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         sec_tick,
   input  logic                         set_valid,
   input  logic [HOUR_W-1:0]            set_hour,
   input  logic [MIN_W-1:0]             set_min,
   input  logic [SEC_W-1:0]             set_sec,
   input  logic                         mode_12h,
   input  logic [HOUR_W*NUM_ALARMS-1:0] alarm_hour,
   input  logic [MIN_W*NUM_ALARMS-1:0]  alarm_min,
   input  logic [SEC_W*NUM_ALARMS-1:0]  alarm_sec,
   input  logic [NUM_ALARMS-1:0]        alarm_en,
   input  logic                         stop,
   input  logic                         snooze,
   output logic [HOUR_W-1:0]            hour,
   output logic [MIN_W-1:0]             min,
   output logic [SEC_W-1:0]             sec,
   output logic [HOUR_W-1:0]            disp_hour,
   output logic                         pm,
   output logic [NUM_ALARMS-1:0]        alarm_active,
   output logic                         alarm_out,
   output logic                         set_err
);
   logic                  time_changed;
   logic                  load_bad;
   logic [NUM_ALARMS-1:0] match;

   assign load_bad = (set_hour > HOUR_W'(MAX_HOUR)) ||
                     (set_min  > MIN_W'(MAX_MIN))   ||
                     (set_sec  > SEC_W'(MAX_SEC));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hour         <= '0;
         min          <= '0;
         sec          <= '0;
         time_changed <= 1'b0;
         set_err      <= 1'b0;
      end else if (set_valid) begin
         // a rejected load also swallows any tick arriving in the same cycle
         if (load_bad) begin
            time_changed <= 1'b0;
            set_err      <= 1'b1;
         end else begin
            hour         <= set_hour;
            min          <= set_min;
            sec          <= set_sec;
            time_changed <= 1'b1;
            set_err      <= 1'b0;
         end
      end else if (sec_tick) begin
         time_changed <= 1'b1;
         set_err      <= 1'b0;
         if (sec == SEC_W'(MAX_SEC)) begin
            sec <= '0;
            if (min == MIN_W'(MAX_MIN)) begin
               min  <= '0;
               hour <= (hour == HOUR_W'(MAX_HOUR)) ? '0 : hour + HOUR_W'(1);
            end else begin
               min <= min + MIN_W'(1);
            end
         end else begin
            sec <= sec + SEC_W'(1);
         end
      end else begin
         time_changed <= 1'b0;
         set_err      <= 1'b0;
      end
   end

   assign pm = (hour >= HOUR_W'(12));

   always_comb begin
      disp_hour = hour;
      if (mode_12h) begin
         if (hour == '0) disp_hour = HOUR_W'(12);
         else if (hour > HOUR_W'(12)) disp_hour = hour - HOUR_W'(12);
      end
   end

   for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
      assign match[i] = time_changed &&
                        (alarm_hour[HOUR_W*i +: HOUR_W] == hour) &&
                        (alarm_min[MIN_W*i +: MIN_W]    == min)  &&
                        (alarm_sec[SEC_W*i +: SEC_W]    == sec);

      alarm_channel #(
         .RING_SEC   (RING_SEC),
         .SNOOZE_SEC (SNOOZE_SEC)
      ) u_ch (
         .clk      (clk),
         .reset_n  (reset_n),
         .sec_tick (sec_tick),
         .match    (match[i]),
         .en       (alarm_en[i]),
         .stop     (stop),
         .snooze   (snooze),
         .ringing  (alarm_active[i])
      );
   end

   assign alarm_out = |alarm_active;
endmodule
